// File: rtl/snake_input_ctrl.sv
// Button synchroniser/debouncer, turn filter and move-tick generator for the snake game.
// Define SNAKE_TURN_QUEUE_EN for a 2-entry turn FIFO; otherwise a single pending turn is kept.
module snake_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 250000,
    parameter int unsigned DB_W         = 18,
    parameter int unsigned TICK_CYC     = 2500000,
    parameter int unsigned TICK_W       = 22
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iUpButton,
    input  logic       iDownButton,
    input  logic       iLeftButton,
    input  logic       iRightButton,
    input  logic       iEnable,
    output logic [1:0] oDirection,
    output logic       oMoveTick,
    output logic       oOverflow
);

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    // Bit order: 3 up, 2 down, 1 left, 0 right (also the priority order).
    logic [3:0]      btnRaw;
    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      dbState;
    logic [DB_W-1:0] dbCnt [4];
    logic [3:0]      dbFlip;
    logic [3:0]      pressEvt;

    logic            candValid;
    logic [1:0]      cand;
    logic [1:0]      refDir;
    logic            legal;

    logic [TICK_W-1:0] tickCnt;
    logic              tickWrap;

    assign btnRaw = {iUpButton, iDownButton, iLeftButton, iRightButton};

    always_comb begin
        dbFlip   = '0;
        pressEvt = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            dbFlip[i]   = (sync2[i] != dbState[i]) && (dbCnt[i] == DB_W'(DEBOUNCE_CYC - 1));
            pressEvt[i] = dbFlip[i] && !dbState[i];
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1   <= '0;
            sync2   <= '0;
            dbState <= '0;
            for (int unsigned i = 0; i < 4; i++) dbCnt[i] <= '0;
        end else begin
            sync1 <= btnRaw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == dbState[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbFlip[i]) begin
                    dbCnt[i]   <= '0;
                    dbState[i] <= ~dbState[i];
                end else begin
                    dbCnt[i] <= dbCnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        candValid = |pressEvt;
        cand      = DIR_RIGHT;
        if (pressEvt[3])      cand = DIR_UP;
        else if (pressEvt[2]) cand = DIR_DOWN;
        else if (pressEvt[1]) cand = DIR_LEFT;
    end

    assign tickWrap = iEnable && (tickCnt == TICK_W'(TICK_CYC - 1));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            tickCnt   <= '0;
            oMoveTick <= 1'b0;
        end else begin
            oMoveTick <= tickWrap;
            if (!iEnable || tickWrap) tickCnt <= '0;
            else                      tickCnt <= tickCnt + TICK_W'(1);
        end
    end

`ifdef SNAKE_TURN_QUEUE_EN
    logic [1:0] q0;
    logic [1:0] q1;
    logic [1:0] qCount;
    logic       pop;

    assign pop = tickWrap && (qCount != 2'd0);

    always_comb begin
        refDir = oDirection;
        if (qCount == 2'd1)      refDir = q0;
        else if (qCount == 2'd2) refDir = q1;
        legal = candValid && (cand != refDir) && ((cand ^ refDir) != 2'b11);
    end

    // q0 is the head; a simultaneous pop+push shifts and refills so the count holds.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            q0         <= '0;
            q1         <= '0;
            qCount     <= '0;
            oDirection <= DIR_RIGHT;
            oOverflow  <= 1'b0;
        end else begin
            oOverflow <= legal && !pop && (qCount == 2'd2);
            if (pop) oDirection <= q0;
            case ({pop, legal})
                2'b10: begin
                    q0     <= q1;
                    qCount <= qCount - 2'd1;
                end
                2'b01: begin
                    if (qCount == 2'd0) begin
                        q0     <= cand;
                        qCount <= 2'd1;
                    end else if (qCount == 2'd1) begin
                        q1     <= cand;
                        qCount <= 2'd2;
                    end
                end
                2'b11: begin
                    if (qCount == 2'd1) begin
                        q0 <= cand;
                    end else begin
                        q0 <= q1;
                        q1 <= cand;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic [1:0] pend;
    logic       pendValid;

    always_comb begin
        refDir = oDirection;
        legal  = candValid && (cand != refDir) && ((cand ^ refDir) != 2'b11);
    end

    // A press landing on the tick edge becomes the next pending turn.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pend       <= '0;
            pendValid  <= 1'b0;
            oDirection <= DIR_RIGHT;
        end else begin
            if (tickWrap && pendValid) begin
                oDirection <= pend;
                pendValid  <= 1'b0;
            end
            if (legal) begin
                pend      <= cand;
                pendValid <= 1'b1;
            end
        end
    end

    assign oOverflow = 1'b0;
`endif

endmodule
